// File: rtl/barrel_unrotator_pipe_if.sv
// Valid/ready handshake bundle for the barrel unrotator: upstream word/amount in, restored word out.
interface barrel_unrotator_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/barrel_unrotator_pipe.sv
// Pipelined left rotator undoing the right-rotate scrambler; stage i rotates by 2^i when its
// amount bit is set, with valid/ready flow control and bubble-collapsing backpressure.
module barrel_unrotator_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    barrel_unrotator_pipe_if.slave bus
);

    logic [AMT_W-1:0] vld_q;
    logic [WIDTH-1:0] data_q   [AMT_W];
    logic [AMT_W-1:0] amt_q    [AMT_W];

    logic [AMT_W-1:0] rdy;
    logic [AMT_W-1:0] up_valid;
    logic [WIDTH-1:0] up_data  [AMT_W];
    logic [AMT_W-1:0] up_amt   [AMT_W];
    logic [WIDTH-1:0] rot_data [AMT_W];

    for (genvar i = 0; i < AMT_W; i++) begin : g_stage
        localparam int unsigned Sh = 1 << i;

        if (i == 0) begin : g_first
            assign up_valid[i] = bus.in_valid;
            assign up_data[i]  = bus.in_data;
            assign up_amt[i]   = bus.in_amt;
        end else begin : g_next
            assign up_valid[i] = vld_q[i-1];
            assign up_data[i]  = data_q[i-1];
            assign up_amt[i]   = amt_q[i-1];
        end

        // Amount is kept shifted so bit 0 is always the bit for the stage being loaded.
        assign rot_data[i] = up_amt[i][0] ? ((up_data[i] << Sh) | (up_data[i] >> (WIDTH - Sh)))
                                          : up_data[i];

        // Flattened ready chain: a stage may load if any stage from it to the output is empty.
        assign rdy[i] = bus.out_ready | ~(&vld_q[AMT_W-1:i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < AMT_W; i++) begin
                data_q[i] <= '0;
                amt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < AMT_W; i++) begin
                if (rdy[i]) begin
                    vld_q[i] <= up_valid[i];
                    if (up_valid[i]) begin
                        data_q[i] <= rot_data[i];
                        amt_q[i]  <= up_amt[i] >> 1;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld_q[AMT_W-1];
    assign bus.out_data  = data_q[AMT_W-1];

endmodule
